// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU requester-side issue controller:
//   - ALU funct codes understood by the ALU
//   - 3-bit state encoding of the issue sequencer
//   - helpers classifying a funct code as legal and/or multi-cycle
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int FUNCT_W = 12;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD   = 12'h020;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB   = 12'h022;
  localparam logic [FUNCT_W-1:0] FUNCT_MULLO = 12'h018;
  localparam logic [FUNCT_W-1:0] FUNCT_MULHI = 12'h019;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVQ  = 12'h01A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVR  = 12'h01B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } issue_state_e;

  // Multiply and divide need a start pulse and a wait for alu_ready.
  function automatic logic is_multicycle(input logic [FUNCT_W-1:0] funct);
    return (funct == FUNCT_MULLO) || (funct == FUNCT_MULHI) ||
           (funct == FUNCT_DIVQ)  || (funct == FUNCT_DIVR);
  endfunction

  function automatic logic is_legal(input logic [FUNCT_W-1:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || is_multicycle(funct);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
// Requester-side sequencer for the ALU, between decode/register-read and
// writeback. Accepts one op per valid/ready handshake, holds funct/operands
// stable on the ALU inputs, pulses alu_start for multi-cycle ops, waits for
// alu_ready (bounded by TIMEOUT), and returns result + tag on a valid/ready
// response port.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_funct/a/b/tag   operation, operands, destination tag
//   alu_funct/a/b       held operation to the ALU
//   alu_start           one-cycle start pulse for multiply/divide
//   alu_result          ALU result for the current alu_funct
//   alu_ready           multi-cycle result valid
//   rsp_valid/rsp_ready response handshake
//   rsp_data/tag/err    result, tag, illegal-funct or timeout flag
// ----------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [11:0]      req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [11:0]      alu_funct,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic             alu_start,
  input  logic [31:0]      alu_result,
  input  logic             alu_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  issue_state_e     state_q, state_d;
  logic [11:0]      funct_q, funct_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and holding registers. The operand/funct registers are only
  // rewritten on accept, so the ALU inputs stay stable between accepts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      funct_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      funct_q <= funct_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. alu_ready is deliberately not looked at in START
  // because it may still be high from the previous operation. In WAIT a
  // ready seen on the last counted cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    funct_d = funct_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          funct_d = req_funct;
          a_d     = req_a;
          b_d     = req_b;
          tag_d   = req_tag;
          if (!is_legal(req_funct)) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (is_multicycle(req_funct)) begin
            state_d = ST_START;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        data_d  = alu_result;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end

      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (alu_ready) begin
          data_d  = alu_result;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign alu_start = (state_q == ST_START);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_funct = funct_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_data  = data_q;
  assign rsp_tag   = tag_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Self-checking bench for alu_issue_ctrl. A behavioural ALU answers the
// controller with a programmable ready latency (0 = never ready). Each
// transaction's expected response, latency and start-pulse count is derived
// from the op class and ALU latency alone.
// ----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int TAG_W   = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [11:0]      req_funct;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [11:0]      alu_funct;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic             alu_start;
  logic [31:0]      alu_result;
  logic             alu_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  int   checks = 0;
  int   failures = 0;
  int   startCount = 0;
  int   aluLatency = 0;
  int   aluCnt = 0;
  logic aluModelReady = 1'b0;
  logic forceReady = 1'b0;

  alu_issue_ctrl #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct  (req_funct),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .alu_funct  (alu_funct),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .alu_ready  (alu_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // Arithmetic the ALU performs; unknown codes return a marker value that
  // must never reach rsp_data.
  function automatic logic [31:0] aluFn(input logic [11:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'b0, a} * {32'b0, b};
    case (f)
      FUNCT_ADD:   return a + b;
      FUNCT_SUB:   return a - b;
      FUNCT_MULLO: return prod[31:0];
      FUNCT_MULHI: return prod[63:32];
      FUNCT_DIVQ:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      FUNCT_DIVR:  return (b == 0) ? a : a % b;
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = aluFn(alu_funct, alu_a, alu_b);
  assign alu_ready = aluModelReady | forceReady;

  // ALU ready model: ready rises in the cycle that is aluLatency cycles after
  // the start cycle and then stays high (stale) until the next start.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      aluCnt = 0;
      aluModelReady = 1'b0;
    end else if (alu_start) begin
      startCount++;
      aluCnt = aluLatency;
      aluModelReady = 1'b0;
    end else if (aluCnt > 0) begin
      aluCnt--;
      if (aluCnt == 0) aluModelReady = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one op starting at a negedge, keeps junk requests asserted while
  // busy, stalls the response for 'stall' cycles, and checks everything.
  task automatic applyStimulus(input logic [11:0] funct, input logic [31:0] a,
                               input logic [31:0] b, input logic [TAG_W-1:0] tag,
                               input int latency, input int stall);
    logic [31:0] expData;
    logic        expErr;
    int          expLat;
    int          expStarts;
    int          startBase;
    int          cyc;

    if (funct == FUNCT_ADD || funct == FUNCT_SUB) begin
      expData = aluFn(funct, a, b); expErr = 1'b0; expLat = 2; expStarts = 0;
    end else if (funct == FUNCT_MULLO || funct == FUNCT_MULHI ||
                 funct == FUNCT_DIVQ || funct == FUNCT_DIVR) begin
      expStarts = 1;
      if (latency >= 1 && latency <= TIMEOUT) begin
        expData = aluFn(funct, a, b); expErr = 1'b0; expLat = latency + 2;
      end else begin
        expData = '0; expErr = 1'b1; expLat = TIMEOUT + 2;
      end
    end else begin
      expData = '0; expErr = 1'b1; expLat = 1; expStarts = 0;
    end

    startBase  = startCount;
    aluLatency = latency;
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_funct  = funct;
    req_a      = a;
    req_b      = b;
    req_tag    = tag;
    checkOutput("req_ready_idle", req_ready, 1);

    @(negedge clk);
    cyc = 1;
    req_funct = 12'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    req_tag   = TAG_W'($urandom);
    while (!rsp_valid && cyc < 200) begin
      checkOutput("req_ready_busy", req_ready, 0);
      @(negedge clk);
      cyc++;
    end
    checkOutput("rsp_valid_seen", rsp_valid, 1);
    checkOutput("latency", cyc, expLat);

    for (int s = 0; s <= stall; s++) begin
      checkOutput("rsp_data", rsp_data, expData);
      checkOutput("rsp_tag", rsp_tag, tag);
      checkOutput("rsp_err", rsp_err, expErr);
      checkOutput("rsp_valid_hold", rsp_valid, 1);
      checkOutput("req_ready_resp", req_ready, 0);
      if (s < stall) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checkOutput("rsp_valid_drop", rsp_valid, 0);
    checkOutput("req_ready_back", req_ready, 1);
    checkOutput("alu_funct_held", alu_funct, funct);
    checkOutput("alu_a_held", alu_a, a);
    checkOutput("alu_b_held", alu_b, b);
    checkOutput("start_pulses", startCount - startBase, expStarts);
  endtask

  initial begin
    logic [11:0] f;
    int          lat;
    logic [11:0] legal [6];
    legal = '{FUNCT_ADD, FUNCT_SUB, FUNCT_MULLO, FUNCT_MULHI, FUNCT_DIVQ, FUNCT_DIVR};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_funct = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    #12;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_alu_start", alu_start, 0);
    checkOutput("rst_alu_funct", alu_funct, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_tag", rsp_tag, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(FUNCT_ADD,   32'd5,       32'd7,       5'd3, 0,  0);
    applyStimulus(FUNCT_MULLO, 32'h1_0000,  32'h10,      5'd1, 33, 0);
    applyStimulus(FUNCT_DIVQ,  32'd100,     32'd7,       5'd2, 0,  0);
    applyStimulus(12'h3FF,     32'd1,       32'd2,       5'd4, 0,  0);
    applyStimulus(FUNCT_SUB,   32'd3,       32'd5,       5'd5, 0,  10);
    applyStimulus(FUNCT_MULHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, TIMEOUT, 0);
    applyStimulus(FUNCT_DIVR,  32'd100,     32'd7,       5'd7, TIMEOUT + 1, 0);
    applyStimulus(FUNCT_DIVQ,  32'd9,       32'd0,       5'd8, 1,  2);
    applyStimulus(FUNCT_DIVR,  32'd100,     32'd7,       5'd9, 3,  0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) f = legal[$urandom_range(0, 5)];
      else f = 12'($urandom);
      lat = $urandom_range(0, 80);
      applyStimulus(f, $urandom, $urandom, TAG_W'($urandom), lat,
                    $urandom_range(0, 3));
    end

    $display("[TB] reset during wait");
    aluLatency = 0;
    req_valid  = 1'b1;
    req_funct  = FUNCT_DIVR;
    req_a      = 32'd77;
    req_b      = 32'd5;
    req_tag    = 5'd17;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    begin
      int base;
      base = startCount;
      reset = 1'b0;
      forceReady = 1'b1;
      #1;
      checkOutput("mid_rst_req_ready", req_ready, 1);
      checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
      checkOutput("mid_rst_alu_funct", alu_funct, 0);
      checkOutput("mid_rst_alu_a", alu_a, 0);
      checkOutput("mid_rst_alu_b", alu_b, 0);
      checkOutput("mid_rst_rsp_tag", rsp_tag, 0);
      checkOutput("mid_rst_rsp_err", rsp_err, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      forceReady = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        checkOutput("post_rst_rsp_valid", rsp_valid, 0);
        checkOutput("post_rst_req_ready", req_ready, 1);
        checkOutput("post_rst_alu_start", alu_start, 0);
      end
      checkOutput("post_rst_starts", startCount - base, 0);
    end
    applyStimulus(FUNCT_ADD, 32'd40, 32'd2, 5'd31, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Requester-side sequencer for the ALU.
- Accepts one operation per valid/ready handshake, drives the ALU's funct/operand inputs and holds them stable, and pulses a start for multi-cycle ops (multiply, divide).
- Waits for the ALU ready, captures the result, and returns it with a tag through a valid/ready response port.
- Sits between the decode/register-read stage and writeback.

Parameters:
- TIMEOUT, 64, maximum cycles to wait for alu_ready before aborting with error.
- TAG_W, 5, width of the destination tag carried with each op.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_funct  in  12  operation code.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_tag  in  TAG_W  destination tag.
- alu_funct  out  12  funct to ALU.
- alu_a  out  32  operand A to ALU.
- alu_b  out  32  operand B to ALU.
- alu_start  out  1  one-cycle start pulse for multi-cycle ops.
- alu_result  in  32  ALU result, selected by alu_funct.
- alu_ready  in  1  multi-cycle result valid.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  result.
- rsp_tag  out  TAG_W  tag of the completed op.
- rsp_err  out  1  illegal funct or timeout.

Behaviour:
- Funct codes:
  - ADD=0x020, SUB=0x022: single-cycle.
  - MULLO=0x018, MULHI=0x019, DIVQ=0x01A, DIVR=0x01B: multi-cycle.
  - All other codes are illegal.
- Reset (reset=0, async):
  - State IDLE.
  - req_ready=1.
  - All other outputs 0, including alu_funct/a/b, rsp_data, rsp_tag, rsp_err, timeout counter.
- States: IDLE, EXEC, START, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid:
    - Latch funct/a/b/tag into holding registers that drive alu_*.
    - Single-cycle op -> EXEC.
    - Multi-cycle op -> START.
    - Illegal op -> RESP with rsp_err=1, rsp_data=0.
  - req_ready=0 in every other state.
- EXEC: capture alu_result into rsp_data, rsp_err=0 -> RESP. Accept-to-rsp_valid latency is 2 cycles.
- START:
  - alu_start=1 for exactly this cycle.
  - alu_ready is ignored in this cycle, because it may be stale from the previous op.
  - Clear the timeout counter -> WAIT.
- WAIT:
  - alu_ready=1: capture alu_result, rsp_err=0 -> RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without alu_ready: rsp_data=0, rsp_err=1 -> RESP.
  - If alu_ready arrives in the same cycle the counter reaches TIMEOUT-1, ready wins.
- RESP:
  - rsp_valid=1; rsp_data, rsp_tag and rsp_err are held stable until rsp_ready.
  - On rsp_ready -> IDLE; rsp_valid drops the next cycle.
  - No new request is accepted in the cycle the response is taken; back-to-back throughput is one op per 3 cycles minimum.
- alu_funct/a/b remain stable from the accept cycle until the next accept; they are not cleared on return to IDLE.
- Divide by zero is not special-cased; whatever the ALU returns is forwarded with rsp_err=0.
- Reset mid-operation aborts immediately: no response and no alu_start are emitted.

Decomposition:
- Shared package alu_pkg:
  - localparam funct codes (FUNCT_ADD, FUNCT_SUB, FUNCT_MULLO, FUNCT_MULHI, FUNCT_DIVQ, FUNCT_DIVR).
  - State encoding (3-bit).
  - Function is_multicycle(funct) and is_legal(funct).
- No sub-module needed; the timeout counter is inline.

Test Plan:
- ADD a=5, b=7, tag=3; rsp_ready held 1 -> rsp_valid 2 cycles after accept, rsp_data=12, rsp_tag=3, rsp_err=0, alu_start never asserted.
- MULLO a=0x10000, b=0x10; ALU model asserts ready 33 cycles after start -> exactly one alu_start pulse, rsp_data=0x100000, rsp_err=0, req_ready low throughout.
- DIVQ with a model that never asserts ready, TIMEOUT=64 -> rsp_valid 64 cycles after leaving START, rsp_data=0, rsp_err=1.
- Illegal funct 0x3FF -> rsp_valid next cycle with rsp_err=1, rsp_data=0, no alu_start.
- SUB 3-5 with rsp_ready held 0 for 10 cycles -> rsp_data=0xFFFFFFFE held stable; req_valid asserted during this time is not accepted; on rsp_ready, IDLE and a new accept is possible.
- reset pulsed low during WAIT of DIVR, alu_ready asserted during the reset -> all outputs 0 immediately, req_ready=1 after release, no rsp_valid.
